// File: rtl/branch_predict_unit_pkg.sv
// branch_predict_unit_pkg: shared branch funct3 codes, BHT defaults and counter reset value.
package branch_predict_unit_pkg;
    localparam int DEF_IDX_BITS = 6;
    localparam int DEF_CTR_BITS = 2;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    function automatic int ctr_reset(input int w);
        return (1 << (w - 1)) - 1;
    endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up/down counter that sticks at 0 and all-ones, synchronous active-low reset to RST.
module sat_counter #(
    parameter int W = 2,
    parameter logic [W-1:0] RST = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] q
);
    always_ff @(posedge clk)
        if (!rst_n) q <= RST;
        else if (inc && !(&q)) q <= q + 1'b1;
        else if (dec && |q) q <= q - 1'b1;
endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: EX-stage RV32I branch resolver with a PC-indexed saturating-counter BHT
// predicting in IF, plus saturating branch/mispredict statistics.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int IDX_BITS = DEF_IDX_BITS,
    parameter int CTR_BITS = DEF_CTR_BITS,
    parameter int STAT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       if_pc,
    output logic              if_pred_taken,
    input  logic              ex_valid,
    input  logic              ex_stall,
    input  logic              ex_branch,
    input  logic [2:0]        ex_funct3,
    input  logic              ex_zero,
    input  logic              ex_less,
    input  logic              ex_less_u,
    input  logic [31:0]       ex_pc,
    input  logic              ex_pred_taken,
    output logic              br_taken,
    output logic              mispredict,
    output logic              illegal_br,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);
    localparam int DEPTH = 1 << IDX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(ctr_reset(CTR_BITS));
    logic [CTR_BITS-1:0] bht [DEPTH];
    logic [IDX_BITS-1:0] if_idx, ex_idx;
    logic live, commit, train, cond;
    logic unused_pc_bits;
    assign if_idx = if_pc[IDX_BITS+1:2];
    assign ex_idx = ex_pc[IDX_BITS+1:2];
    assign unused_pc_bits = ^{if_pc[31:IDX_BITS+2], if_pc[1:0], ex_pc[31:IDX_BITS+2], ex_pc[1:0]};
    always_comb begin
        live = ex_valid & ex_branch;
        commit = live & ~ex_stall;
        cond = (ex_funct3 == F3_BEQ)  ? ex_zero    :
               (ex_funct3 == F3_BNE)  ? ~ex_zero   :
               (ex_funct3 == F3_BLT)  ? ex_less    :
               (ex_funct3 == F3_BGE)  ? ~ex_less   :
               (ex_funct3 == F3_BLTU) ? ex_less_u  :
               (ex_funct3 == F3_BGEU) ? ~ex_less_u : 1'b0;
        illegal_br = live & !(ex_funct3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU});
        br_taken = live & cond;
        mispredict = live & ~illegal_br & (br_taken != ex_pred_taken);
        train = commit & ~illegal_br;
    end
    // no write bypass: IF sees the pre-update counter on a same-index collision
    assign if_pred_taken = bht[if_idx][CTR_BITS-1];
    genvar i;
    for (i = 0; i < DEPTH; i++) begin : g_bht
        sat_counter #(.W(CTR_BITS), .RST(CTR_RST)) u_ctr (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (train & (ex_idx == IDX_BITS'(i)) & br_taken),
            .dec   (train & (ex_idx == IDX_BITS'(i)) & ~br_taken),
            .q     (bht[i])
        );
    end
    sat_counter #(.W(STAT_W)) u_stat_br (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (commit),
        .dec   (1'b0),
        .q     (stat_branches)
    );
    sat_counter #(.W(STAT_W)) u_stat_mp (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (commit & mispredict),
        .dec   (1'b0),
        .q     (stat_mispredicts)
    );
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed and random stimulus against an integer-array BHT/stats model;
// a second instance with 4-bit stats exercises statistics saturation.
module tb_branch_predict_unit;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [31:0] if_pc = '0, ex_pc = '0;
    logic ex_valid = 1'b0, ex_stall = 1'b0, ex_branch = 1'b0, ex_zero = 1'b0;
    logic ex_less = 1'b0, ex_less_u = 1'b0, ex_pred_taken = 1'b0;
    logic [2:0] ex_funct3 = '0;
    logic if_pred_taken, br_taken, mispredict, illegal_br;
    logic [31:0] stat_branches, stat_mispredicts;
    logic s_pred, s_taken, s_mis, s_ill;
    logic [3:0] s_br, s_mp;
    int total = 0, bad = 0;
    int m_bht [64];
    longint br_n = 0, mp_n = 0;

    always #5 clk = ~clk;

    branch_predict_unit dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_branch(ex_branch), .ex_funct3(ex_funct3),
        .ex_zero(ex_zero), .ex_less(ex_less), .ex_less_u(ex_less_u), .ex_pc(ex_pc),
        .ex_pred_taken(ex_pred_taken), .br_taken(br_taken), .mispredict(mispredict),
        .illegal_br(illegal_br), .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    branch_predict_unit #(.STAT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(s_pred),
        .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_branch(ex_branch), .ex_funct3(ex_funct3),
        .ex_zero(ex_zero), .ex_less(ex_less), .ex_less_u(ex_less_u), .ex_pc(ex_pc),
        .ex_pred_taken(ex_pred_taken), .br_taken(s_taken), .mispredict(s_mis),
        .illegal_br(s_ill), .stat_branches(s_br), .stat_mispredicts(s_mp)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_taken();
        if (!(ex_valid && ex_branch)) return 1'b0;
        case (ex_funct3)
            3'b000: return ex_zero;
            3'b001: return !ex_zero;
            3'b100: return ex_less;
            3'b101: return !ex_less;
            3'b110: return ex_less_u;
            3'b111: return !ex_less_u;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_ill();
        return ex_valid && ex_branch && (ex_funct3 == 3'b010 || ex_funct3 == 3'b011);
    endfunction

    function automatic int idx(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    function automatic longint sat(input longint v, input int w);
        longint mx = (longint'(1) << w) - 1;
        return v > mx ? mx : v;
    endfunction

    task automatic m_reset();
        foreach (m_bht[k]) m_bht[k] = 1;
        br_n = 0;
        mp_n = 0;
    endtask

    // check every output against the model, then advance one edge and update the model
    task automatic cycle();
        bit t, il, mi, cm;
        int e;
        #2;
        t = m_taken();
        il = m_ill();
        mi = ex_valid && ex_branch && !il && (t != ex_pred_taken);
        cm = ex_valid && ex_branch && !ex_stall;
        chk("br_taken", br_taken, t);
        chk("illegal_br", illegal_br, il);
        chk("mispredict", mispredict, mi);
        chk("if_pred", if_pred_taken, m_bht[idx(if_pc)] >= 2);
        chk("stat_br", stat_branches, sat(br_n, 32));
        chk("stat_mp", stat_mispredicts, sat(mp_n, 32));
        chk("s_stat_br", s_br, sat(br_n, 4));
        chk("s_stat_mp", s_mp, sat(mp_n, 4));
        @(posedge clk);
        if (!rst_n) m_reset();
        else if (cm) begin
            br_n++;
            if (mi) mp_n++;
            if (!il) begin
                e = idx(ex_pc);
                m_bht[e] = t ? (m_bht[e] < 3 ? m_bht[e] + 1 : 3) : (m_bht[e] > 0 ? m_bht[e] - 1 : 0);
            end
        end
        #1;
    endtask

    task automatic br(input logic [2:0] f3, input logic z, input logic l, input logic lu,
                      input logic [31:0] pc, input logic p, input logic st);
        ex_valid = 1'b1; ex_branch = 1'b1; ex_stall = st; ex_funct3 = f3;
        ex_zero = z; ex_less = l; ex_less_u = lu; ex_pc = pc; ex_pred_taken = p; if_pc = pc;
    endtask

    task automatic idle(input logic [31:0] pc);
        ex_valid = 1'b0; ex_branch = 1'b0; ex_stall = 1'b0; if_pc = pc;
    endtask

    initial begin
        rst_n = 1'b0;
        @(posedge clk);
        m_reset();
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(32'h0); #1;
        chk("rst_pred_00", if_pred_taken, 1'b0);
        chk("rst_stat_br", stat_branches, 32'd0);
        chk("rst_stat_mp", stat_mispredicts, 32'd0);
        cycle();
        idle(32'hFC); #1;
        chk("rst_pred_fc", if_pred_taken, 1'b0);
        cycle();
        br(3'b000, 1, 0, 0, 32'h40, 0, 0); #1;
        chk("beq_taken", br_taken, 1'b1);
        chk("beq_mis", mispredict, 1'b1);
        chk("beq_pred_same_cycle", if_pred_taken, 1'b0);
        cycle();
        idle(32'h40); #1;
        chk("beq_pred_next", if_pred_taken, 1'b1);
        chk("beq_stat_br", stat_branches, 32'd1);
        chk("beq_stat_mp", stat_mispredicts, 32'd1);
        cycle();
        repeat (5) begin br(3'b101, 0, 0, 0, 32'h80, 1, 0); cycle(); end
        br(3'b101, 0, 1, 0, 32'h80, 1, 0); cycle();
        idle(32'h80); #1;
        chk("bge_pred_after_nt", if_pred_taken, 1'b1);
        cycle();
        br(3'b101, 0, 1, 0, 32'h80, 1, 0); cycle();
        idle(32'h80); #1;
        chk("bge_pred_after_2nt", if_pred_taken, 1'b0);
        cycle();
        br(3'b110, 0, 0, 1, 32'hC0, 0, 0); #1;
        chk("bltu_taken", br_taken, 1'b1);
        cycle();
        br(3'b111, 0, 0, 1, 32'hC0, 0, 0); #1;
        chk("bgeu_taken", br_taken, 1'b0);
        cycle();
        repeat (3) begin
            br(3'b000, 1, 0, 0, 32'h104, 0, 1); #1;
            chk("stall_mis", mispredict, 1'b1);
            cycle();
        end
        ex_stall = 1'b0; #1;
        chk("stall_release_mis", mispredict, 1'b1);
        cycle();
        idle(32'h104); #1;
        chk("stall_pred", if_pred_taken, 1'b1);
        chk("stall_stat_br", stat_branches, 32'(br_n));
        cycle();
        br(3'b001, 1, 0, 0, 32'h104, 1, 0); cycle();
        idle(32'h104); #1;
        chk("stall_single_step", if_pred_taken, 1'b0);
        cycle();
        br(3'b010, 1, 1, 1, 32'h40, 1, 0); #1;
        chk("ill_flag", illegal_br, 1'b1);
        chk("ill_taken", br_taken, 1'b0);
        chk("ill_mis", mispredict, 1'b0);
        cycle();
        idle(32'h40); #1;
        chk("ill_no_train", if_pred_taken, 1'b1);
        cycle();
        for (int n = 0; n < 400; n++) begin
            rst_n = (n >= 300) || ($urandom_range(0, 49) != 0);
            ex_valid = $urandom_range(0, 9) != 0;
            ex_branch = $urandom_range(0, 7) != 0;
            ex_stall = $urandom_range(0, 3) == 0;
            ex_funct3 = 3'($urandom);
            ex_zero = 1'($urandom);
            ex_less = 1'($urandom);
            ex_less_u = 1'($urandom);
            ex_pred_taken = 1'($urandom);
            ex_pc = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7)) << 2;
            if_pc = ($urandom_range(0, 1) == 0) ? ex_pc : 32'($urandom_range(0, 7)) << 2;
            cycle();
        end
        rst_n = 1'b1;
        idle(32'h0); #1;
        chk("s_stat_br_sat", s_br, 4'hF);
        cycle();
        br(3'b101, 0, 0, 0, 32'h80, 0, 0);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        idle(32'h0); #1;
        chk("rst_commit_br", stat_branches, 32'd0);
        chk("rst_commit_mp", stat_mispredicts, 32'd0);
        chk("rst_commit_s_br", s_br, 4'd0);
        for (int k = 0; k < 64; k++) begin
            if_pc = 32'(k) << 2; #1;
            chk("rst_sweep_pred", if_pred_taken, 1'b0);
        end
        cycle();
        br(3'b101, 0, 0, 0, 32'h80, 0, 0); cycle();
        idle(32'h80); #1;
        chk("rst_value_weak_nt", if_pred_taken, 1'b1);
        cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised next-generation branch resolver for the pipelined RV32 core.
- Resolves all six RV32I conditional branches in EX: beq, bne, blt, bge, bltu, bgeu.
- Holds a PC-indexed table (BHT) of saturating counters that supplies a taken/not-taken prediction in IF and is trained in EX.
- Flags mispredictions for the hazard/flush logic and keeps saturating branch and mispredict statistics counters.

Parameters:
- IDX_BITS, 6, BHT index width; depth = 2**IDX_BITS entries.
- CTR_BITS, 2, width of each saturating counter (>=1).
- STAT_W, 32, width of each statistics counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- if_pc  in  32  IF-stage PC; index = if_pc[IDX_BITS+1:2].
- if_pred_taken  out  1  prediction for if_pc: MSB of the indexed counter.
- ex_valid  in  1  EX holds a live instruction.
- ex_stall  in  1  EX held this cycle; instruction repeats next cycle.
- ex_branch  in  1  EX instruction is a conditional branch.
- ex_funct3  in  3  branch funct3.
- ex_zero  in  1  ALU rs1==rs2.
- ex_less  in  1  signed rs1<rs2.
- ex_less_u  in  1  unsigned rs1<rs2.
- ex_pc  in  32  EX PC; index = ex_pc[IDX_BITS+1:2].
- ex_pred_taken  in  1  if_pred_taken value carried down the pipe with this instruction.
- br_taken  out  1  actual branch outcome.
- mispredict  out  1  redirect/flush request.
- illegal_br  out  1  branch with an unsupported funct3.
- stat_branches  out  STAT_W  resolved branches.
- stat_mispredicts  out  STAT_W  mispredicted branches.

Behaviour:
- Let live = ex_valid & ex_branch. A cycle is a "commit" when live & ~ex_stall.
- br_taken is combinational and 0 whenever live=0. Otherwise by funct3:
  - 000 = zero; 001 = ~zero
  - 100 = less; 101 = ~less
  - 110 = less_u; 111 = ~less_u
  - 010/011: br_taken = 0 and illegal_br = 1.
- illegal_br is combinational and is 0 whenever live=0.
- mispredict = live & ~illegal_br & (br_taken != ex_pred_taken). It is combinational and is asserted during stall cycles as well; the flush logic qualifies it.
- Illegal branch: not a mispredict; no BHT update; stat_branches is still incremented on commit.
- BHT update happens on the clock edge of a commit cycle with illegal_br=0:
  - entry[ex_idx] increments if br_taken, else decrements.
  - Counters saturate at 2**CTR_BITS-1 and at 0.
  - No update while ex_stall=1, so each branch trains exactly once.
- if_pred_taken reads the registered array combinationally, with no write bypass. If IF and EX hit the same index in the same cycle, IF sees the pre-update value.
- Statistics, updated on commit edges:
  - stat_branches += 1 on every commit.
  - stat_mispredicts += 1 on commit & mispredict.
  - Both saturate at all-ones and do not wrap.
- Reset, synchronous on rst_n=0 at a rising edge:
  - Every BHT entry is set to weakly-not-taken, 2**(CTR_BITS-1)-1; for CTR_BITS=1 this is 0.
  - Both stats counters are set to 0.
  - If rst_n=0 during a commit cycle, reset wins: no training and no stats increment.
  - Combinational outputs then follow their inputs; if_pred_taken=0 for every PC.
- Latency:
  - Prediction: 0 cycles (same-cycle lookup).
  - Resolution: 0 cycles.
  - Training: visible to IF from the cycle after the commit edge.
- No state machine is needed beyond the counter array; all state is the BHT plus the two stats registers.

Decomposition:
- Shared package/header holds:
  - funct3 constants: F3_BEQ=000, F3_BNE=001, F3_BLT=100, F3_BGE=101, F3_BLTU=110, F3_BGEU=111.
  - Counter reset-value function.
  - Default IDX_BITS/CTR_BITS.
- One sub-module is natural: sat_counter (parameter W, with inc, dec and a synchronous active-low reset value). Instantiate it per BHT entry and reuse it at STAT_W for both stats registers (inc only).

Test Plan:
- Reset then probe if_pc=0x0000_0000 and 0x0000_00FC -> if_pred_taken=0. Both stats read 0.
- beq committed at ex_pc=0x40 with ex_zero=1, ex_pred_taken=0 -> br_taken=1, mispredict=1. Next cycle, if_pc=0x40 gives if_pred_taken=1 (counter 01->10). stat_branches=1, stat_mispredicts=1.
- Same bge at ex_pc=0x80 with ex_less=0 committed 5 times -> counter saturates at 11. Then one not-taken commit -> 10, and if_pred_taken remains 1.
- bltu with ex_less_u=1, ex_less=0 -> br_taken=1. bgeu with the same flags -> br_taken=0. This confirms signed and unsigned selection.
- Branch held with ex_stall=1 for 3 cycles, then released -> mispredict high all 4 cycles, but the counter moves one step and stat_branches increments by exactly 1.
- funct3=010 with live=1 -> illegal_br=1, br_taken=0, mispredict=0, no BHT change. Separately: STAT_W=4 with 16 commits leaves stat_branches=15 (saturated). Asserting rst_n=0 on a commit edge gives stats 0 and all entries at the reset value.
